// File: rtl/div_restoring_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_restoring_pkg;

    typedef enum logic [1:0] {
        DivIdle = 2'b00,
        DivCalc = 2'b01,
        DivFix  = 2'b10,
        DivDone = 2'b11
    } div_state_e;

    localparam int unsigned DIV_ITERS = 32;

endpackage

// File: rtl/div_restoring_if.sv
// Operand request and result handshake between the EX stage and the divider.
interface div_restoring_if #(
    parameter int unsigned WIDTH = 32
);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               sign;
    logic               opn_valid;
    logic               res_valid;
    logic               res_ready;
    logic [2*WIDTH-1:0] result;

    modport master (
        output a, b, sign, opn_valid, res_ready,
        input  res_valid, result
    );

    modport slave (
        input  a, b, sign, opn_valid, res_ready,
        output res_valid, result
    );
endinterface

// File: rtl/div_restoring.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; result is {remainder, quotient} = {HI, LO}.
// One quotient bit per cycle on magnitudes, sign fix-up applied in a final cycle.
module div_restoring
    import div_restoring_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITERS,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    div_restoring_if.slave  bus
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               div_zero_q, div_zero_d;
    logic               res_valid_q, res_valid_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     trial;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        div_zero_d  = div_zero_q;
        res_valid_d = res_valid_q;
        result_d    = result_q;

        // quo_q doubles as the dividend shift register; its MSB feeds the remainder.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = rem_sh - {1'b0, dvs_q};

        unique case (state_q)
            DivIdle: begin
                if (bus.opn_valid) begin
                    quo_d      = neg_if(bus.a, bus.sign & bus.a[WIDTH-1]);
                    dvs_d      = neg_if(bus.b, bus.sign & bus.b[WIDTH-1]);
                    neg_quo_d  = bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_rem_d  = bus.sign & bus.a[WIDTH-1];
                    div_zero_d = (bus.b == '0);
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = DivCalc;
                end
            end
            DivCalc: begin
                if (!bus.opn_valid) begin
                    state_d = DivIdle;
                end else begin
                    rem_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DivFix;
                    end
                end
            end
            DivFix: begin
                if (!bus.opn_valid) begin
                    state_d = DivIdle;
                end else begin
                    if (div_zero_q) begin
                        // rem_q ends up holding |a|; undoing the magnitude gives back a.
                        result_d = {neg_if(rem_q, neg_rem_q), {WIDTH{1'b1}}};
                    end else begin
                        result_d = {neg_if(rem_q, neg_rem_q), neg_if(quo_q, neg_quo_q)};
                    end
                    res_valid_d = 1'b1;
                    state_d     = DivDone;
                end
            end
            DivDone: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = DivIdle;
                end
            end
            default: state_d = DivIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= DivIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            div_zero_q  <= 1'b0;
            res_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            div_zero_q  <= div_zero_d;
            res_valid_q <= res_valid_d;
            result_q    <= result_d;
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_div_restoring.sv
// Self-checking bench for div_restoring: directed boundary cases, abort paths and random ops
// compared cycle by cycle against an arithmetic reference model.
module tb_div_restoring;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          failures = 0;
    logic        exp_valid = 1'b0;
    logic [63:0] exp_result = '0;

    always #5 clk = ~clk;

    div_restoring_if #(.WIDTH(32)) bus();

    div_restoring #(.WIDTH(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer division; SV '/' truncates toward zero and '%' follows dividend.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Cycle-level expectation: res_valid is 0 except between edges E0+33 and the consume edge.
    always @(negedge clk) begin
        if (!rst) begin
            chk("res_valid", 64'(bus.res_valid), 64'(exp_valid));
            if (exp_valid) chk("result", bus.result, exp_result);
        end
    end

    task automatic check_identity(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  input logic [63:0] got);
        logic [31:0] q, r, recon;
        longint      ra, rb;
        q = got[31:0];
        r = got[63:32];
        if (b != 32'd0) begin
            recon = q * b + r;
            chk("identity", 64'(recon), 64'(a));
            if (s) begin
                ra = longint'($signed(r));
                rb = longint'($signed(b));
                if (ra < 0) ra = -ra;
                if (rb < 0) rb = -rb;
                chk("rem_lt_div", 64'(ra < rb), 64'd1);
                chk("rem_sign", 64'((r == 32'd0) || (r[31] == a[31])), 64'd1);
            end else begin
                chk("rem_lt_div", 64'(r < b), 64'd1);
            end
        end
    endtask

    // Called #1 after a posedge with the DUT idle; returns #1 after the consume edge.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp, input int delay, input bit keep);
        logic [63:0] got;
        bus.a         = a;
        bus.b         = b;
        bus.sign      = s;
        bus.opn_valid = 1'b1;
        bus.res_ready = (delay == 0);
        exp_result    = exp;
        @(posedge clk);
        #1;
        bus.a    = $urandom;
        bus.b    = $urandom;
        bus.sign = 1'($urandom_range(0, 1));
        repeat (33) @(posedge clk);
        #1;
        exp_valid = 1'b1;
        got       = bus.result;
        repeat (delay) begin
            @(posedge clk);
            #1;
            bus.a = $urandom;
            bus.b = $urandom;
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_valid     = 1'b0;
        bus.res_ready = 1'b0;
        if (!keep) bus.opn_valid = 1'b0;
        check_identity(a, b, s, got);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        int          sel, dly;
        bit          kp;

        bus.a         = '0;
        bus.b         = '0;
        bus.sign      = 1'b0;
        bus.opn_valid = 1'b0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", bus.result, 64'd0);
        chk("reset_valid", 64'(bus.res_valid), 64'd0);
        rst = 1'b0;

        chk("model_100_7", model(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        chk("model_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), {32'd0, 32'h8000_0000});
        chk("model_div0", model(32'h8765_4321, 32'd0, 1'b1), {32'h8765_4321, 32'hFFFF_FFFF});

        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 0, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, 2, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, 0, 1'b0);
        run_op(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, 0, 1'b0);
        run_op(32'h8765_4321, 32'd0, 1'b1, {32'h8765_4321, 32'hFFFF_FFFF}, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, 0, 1'b0);

        // Backpressure with operands churning, then a back-to-back op with opn_valid held.
        run_op(32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 10, 1'b1);
        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 1'b0);

        // Reset after 15 iterations, then a fresh op right after rst falls.
        bus.a         = 32'd500;
        bus.b         = 32'd3;
        bus.sign      = 1'b0;
        bus.opn_valid = 1'b1;
        @(posedge clk);
        repeat (15) @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.opn_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_rst_valid", 64'(bus.res_valid), 64'd0);
        chk("abort_rst_result", bus.result, 64'd0);
        rst = 1'b0;
        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 0, 1'b0);

        // Drop opn_valid after 20 iterations: no result may ever appear.
        bus.a         = 32'd12345;
        bus.b         = 32'd11;
        bus.opn_valid = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        bus.opn_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_opn_valid", 64'(bus.res_valid), 64'd0);
        run_op(32'd12345, 32'd11, 1'b0, {32'd3, 32'd1122}, 0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ra  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            else if (sel <= 3) rb = 32'($urandom_range(1, 15));
            else if (sel == 4) rb = -32'($urandom_range(1, 15));
            else rb = $urandom;
            if ($urandom_range(0, 15) == 0) ra = 32'h8000_0000;
            rs  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 3);
            kp  = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, model(ra, rb, rs), dly, kp);
        end
        bus.opn_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
